// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the fetch stage's instruction-memory req/ack bus,
//                the branch redirect input and the decode-side valid/ready
//                output into one interface.
//                master - the fetch unit itself
//                slave  - the environment (imem, execute and decode)
//  Signals     : imem_req/imem_addr/imem_ack/imem_rdata  instruction memory
//                branch_en/branch_target                 redirect from execute
//                instr_valid/instr_ready/Instr/instr_pc/PCPlus8  to decode
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] instr_pc;
  logic [31:0] PCPlus8;

  modport master (
    output imem_req, imem_addr, instr_valid, Instr, instr_pc, PCPlus8,
    input  imem_ack, imem_rdata, branch_en, branch_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, Instr, instr_pc, PCPlus8,
    output imem_ack, imem_rdata, branch_en, branch_target, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues word fetches
//                over a req/ack handshake, buffers returned words in a small
//                FIFO and presents the head to decode together with its PC
//                and PC+8 (the r15 read value). Branch redirects flush the
//                buffer and discard any in-flight fetch.
//  Ports       : clk    - clock, all state on the rising edge
//                reset  - asynchronous active-low reset
//                bus    - fetch_unit_if.master (imem, branch, decode signals)
//  Parameters  : DEPTH    - buffer entries (power of 2, >= 2)
//                RESET_PC - PC loaded on reset
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  wire logic       clk,
  input  wire logic       reset,
  fetch_unit_if.master    bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [31:0]   PC_ALIGN = RESET_PC & ~32'd3;

  // IDLE: nothing outstanding. WAIT: request held until ack.
  // DROP: request still held (bus must stay stable) but its data is stale.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_instr_d [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_pc_d    [DEPTH];

  logic          w_valid;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_head_idx;

  assign w_valid = (count_q != '0);
  // An ack only means something while a request is actually on the bus.
  assign w_ack   = bus.imem_ack && (state_q != S_IDLE);
  // A redirect wins over everything: same-cycle data is dropped and a
  // same-cycle pop is ignored because the whole buffer is discarded anyway.
  assign w_push  = w_ack && (state_q == S_WAIT) && !bus.branch_en;
  assign w_pop   = w_valid && bus.instr_ready && !bus.branch_en;
  assign w_count_next = count_q + CW'(w_push) - CW'(w_pop);

  // When empty, show the most recently popped slot so the outputs hold
  // their last values instead of exposing unrelated storage.
  assign w_head_idx = w_valid ? rd_ptr_q : (rd_ptr_q - PTR_ONE);

  assign bus.imem_req    = (state_q != S_IDLE);
  assign bus.imem_addr   = req_addr_q;
  assign bus.instr_valid = w_valid;
  assign bus.Instr       = mem_instr_q[w_head_idx];
  assign bus.instr_pc    = mem_pc_q[w_head_idx];
  assign bus.PCPlus8     = mem_pc_q[w_head_idx] + 32'd8;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;

    if (w_push) begin
      mem_instr_d[wr_ptr_q] = bus.imem_rdata;
      mem_pc_d[wr_ptr_q]    = fetch_pc_q;
    end

    if (bus.branch_en) begin
      fetch_pc_d = bus.branch_target & ~32'd3;
      count_d    = '0;
      // Flush by collapsing the write pointer onto the read pointer; the
      // slot behind rd_ptr keeps the last consumed entry for the hold view.
      wr_ptr_d   = rd_ptr_q;
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_WAIT:  state_d = w_ack ? S_IDLE : S_DROP;
        S_DROP:  state_d = w_ack ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      count_d = w_count_next;
      if (w_push) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // Credit: a new request is only started when, after this cycle's
      // push/pop, a slot is still free for its data. Occupancy can then
      // only fall until the ack, so imem_ack never needs back-pressure.
      case (state_q)
        S_IDLE: begin
          if (w_count_next < DEPTH_C) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (w_ack) state_d = (w_count_next < DEPTH_C) ? S_WAIT : S_IDLE;
        end
        S_DROP: begin
          if (w_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The bus address tracks the fetch PC except while a stale request is
  // being drained, where it must stay on the original address.
  always_comb begin
    req_addr_d = (state_d == S_DROP) ? req_addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= PC_ALIGN;
      req_addr_q <= PC_ALIGN;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_instr_q <= mem_instr_d;
      mem_pc_q    <= mem_pc_d;
    end
  end

endmodule
`default_nettype wire
